reset_gwe_seq: RTL and testbench
================================

RESET_GWE_SEQ -- requirements
Module: reset_gwe_seq

Interface
REQ-001 SHALL have parameter DIV, default 8, meaning the number of clk_16MHz cycles per gwe period; legal values are powers of two, 2..64.
REQ-002 SHALL have parameter HOLD, default 16, meaning the number of gwe periods proc_rst is held after lock.
REQ-003 SHALL have port clk_16MHz, input, 1 bit: single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port dcm_locked, input, 1 bit: upstream DCM lock; asynchronous to the block.
REQ-006 SHALL have port run_sw, input, 1 bit: 1 selects free-run, 0 selects single-step; asynchronous.
REQ-007 SHALL have port step_btn, input, 1 bit: single-step request, already debounced; asynchronous.
REQ-008 SHALL have port gwe, output, 1 bit: global write enable, a one-cycle pulse.
REQ-009 SHALL have port proc_rst, output, 1 bit: synchronous processor reset, active-high.
REQ-010 SHALL have port phase, output, log2(DIV) bits: divider phase count.
REQ-011 SHALL have port state, output, 2 bits: FSM state, for debug.

Function
REQ-012 SHALL pass dcm_locked, run_sw and step_btn each through a 2-flop synchronizer; only the synchronized copies are used internally.
REQ-013 SHALL increment phase every cycle and wrap from DIV-1 to 0; phase free-runs in all states.
REQ-014 SHALL define the tick as phase==DIV-1; gwe SHALL be asserted only on a tick cycle and only as allowed by the FSM.
REQ-015 SHALL implement FSM states WAIT_LOCK=0, HOLD_RST=1, RUN=2 and STEP=3.
REQ-016 WAIT_LOCK: proc_rst=1, gwe=0; on the first tick with lock_s=1, SHALL load hold_cnt=HOLD-1 and go to HOLD_RST.
REQ-017 HOLD_RST: proc_rst=1; gwe SHALL pulse on every tick so that the reset is clocked into downstream registers; on a tick with hold_cnt==0, SHALL go to RUN if run_s=1, else STEP; otherwise SHALL decrement hold_cnt on each tick.
REQ-018 RUN: proc_rst=0, gwe pulses on every tick; on a tick with run_s=0, SHALL go to STEP with no gwe that tick.
REQ-019 STEP: proc_rst=0; a synchronized rising edge of step_btn SHALL set step_pend.
REQ-020 In STEP, on a tick with step_pend=1, SHALL pulse gwe once and clear step_pend.
REQ-021 In STEP, SHALL allow at most one pending step; extra edges before the tick are dropped.
REQ-022 In STEP, on a tick with run_s=1, SHALL go to RUN.
REQ-023 If step_pend=1 and run_s=1 on the same tick in STEP, SHALL emit a gwe pulse, clear step_pend and go to RUN.
REQ-024 Loss of lock_s in any state other than WAIT_LOCK SHALL force WAIT_LOCK on the next cycle, regardless of tick, and SHALL assert proc_rst that cycle.
REQ-025 SHALL change state only on a tick, except for loss of lock.
REQ-026 SHALL drive gwe, proc_rst and state as registered outputs; gwe SHALL be high for exactly one cycle, i.e. the cycle after phase==DIV-1 is registered, aligned to phase==0 as observed.
REQ-027 SHALL size hold_cnt to hold HOLD-1 and SHALL saturate hold_cnt at 0; it never wraps.

Reset
REQ-028 Asserting reset SHALL immediately force state=WAIT_LOCK, phase=0, gwe=0, proc_rst=1, hold_cnt=0, step_pend=0, and all synchronizer flops to 0.
REQ-029 Reset mid-operation SHALL abort any pending step and restart the full lock/hold sequence; no gwe pulse SHALL occur while reset is high.

Verification
REQ-030 Bench SHALL check: dcm_locked=1, run_sw=1, reset released -> proc_rst=1 with exactly 16 gwe pulses, 8 cycles apart; then proc_rst=0 and gwe continues every 8 cycles.
REQ-031 Bench SHALL check: run_sw=0 after hold, three step_btn edges spaced 20 cycles apart -> exactly 3 gwe pulses, each on a phase wrap.
REQ-032 Bench SHALL check: two step_btn edges within one 8-cycle period -> exactly 1 gwe pulse.
REQ-033 Bench SHALL check: dcm_locked dropped in RUN -> state=0 and proc_rst=1 within 3 cycles (synchronizer plus 1); relock -> 16 hold pulses again.
REQ-034 Bench SHALL check: reset pulsed mid-HOLD_RST with hold_cnt=5 -> outputs at reset values immediately; full 16-pulse hold is repeated.
REQ-035 Bench SHALL check: DIV=2, HOLD=1 -> gwe every 2 cycles; one hold pulse before RUN.

Source files
------------

// File: rtl/reset_gwe_seq.sv
// reset_gwe_seq: lock-gated reset sequencer emitting a divided global write enable with run/single-step control
module reset_gwe_seq #(
  parameter int DIV  = 8,
  parameter int HOLD = 16
) (
  input  logic                   clk_16MHz,
  input  logic                   reset,
  input  logic                   dcm_locked,
  input  logic                   run_sw,
  input  logic                   step_btn,
  output logic                   gwe,
  output logic                   proc_rst,
  output logic [$clog2(DIV)-1:0] phase,
  output logic [1:0]             state
);
  localparam int PW = $clog2(DIV);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  typedef enum logic [1:0] {WAIT_LOCK = 2'd0, HOLD_RST = 2'd1, RUN = 2'd2, STEP = 2'd3} state_t;
  state_t st, st_n;
  logic [2:0] sync_1, sync_2;
  logic step_d, pend, pend_n, gwe_n, proc_rst_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic lock_s, run_s, step_rise, tick, lost;
  assign lock_s    = sync_2[2];
  assign run_s     = sync_2[1];
  assign step_rise = sync_2[0] & ~step_d;
  assign tick      = phase == PW'(DIV - 1);
  assign lost      = !lock_s && st != WAIT_LOCK;
  assign state     = st;
  always_ff @(posedge clk_16MHz or posedge reset)
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
      step_d <= 1'b0;
    end else begin
      sync_1 <= {dcm_locked, run_sw, step_btn};
      sync_2 <= sync_1;
      step_d <= sync_2[0];
    end
  // proc_rst follows the current state, so the final hold pulse still sees reset asserted
  always_comb begin
    st_n       = st;
    hold_n     = hold_cnt;
    pend_n     = 1'b0;
    gwe_n      = 1'b0;
    proc_rst_n = lost || st == WAIT_LOCK || st == HOLD_RST;
    if (lost)
      st_n = WAIT_LOCK;
    else
      case (st)
        WAIT_LOCK: if (tick && lock_s) begin
          st_n   = HOLD_RST;
          hold_n = HW'(HOLD - 1);
        end
        HOLD_RST: if (tick) begin
          gwe_n  = 1'b1;
          st_n   = hold_cnt == '0 ? (run_s ? RUN : STEP) : HOLD_RST;
          hold_n = hold_cnt == '0 ? hold_cnt : hold_cnt - 1'b1;
        end
        RUN: if (tick) begin
          gwe_n = run_s;
          st_n  = run_s ? RUN : STEP;
        end
        STEP: begin
          pend_n = tick ? !pend && step_rise : pend | step_rise;
          gwe_n  = tick && pend;
          st_n   = tick && run_s ? RUN : STEP;
        end
      endcase
  end
  always_ff @(posedge clk_16MHz or posedge reset)
    if (reset) begin
      st       <= WAIT_LOCK;
      phase    <= '0;
      gwe      <= 1'b0;
      proc_rst <= 1'b1;
      hold_cnt <= '0;
      pend     <= 1'b0;
    end else begin
      st       <= st_n;
      phase    <= phase + 1'b1;
      gwe      <= gwe_n;
      proc_rst <= proc_rst_n;
      hold_cnt <= hold_n;
      pend     <= pend_n;
    end
endmodule

// File: tb/tb_reset_gwe_seq.sv
// tb_reset_gwe_seq: scoreboard bench for the lock/hold/run/step gwe sequencer
module tb_reset_gwe_seq;
  logic clk = 1'b0, reset = 1'b1, dcm_locked = 1'b1, run_sw = 1'b1, step_btn = 1'b0;
  logic gwe, proc_rst;
  logic [2:0] phase;
  logic [1:0] state;
  logic reset_b = 1'b1, gwe_b, proc_rst_b;
  logic [0:0] phase_b;
  logic [1:0] state_b;
  int tests = 0, fails = 0;
  int exp_q[$];
  always #5 clk = ~clk;
  reset_gwe_seq dut (.clk_16MHz(clk), .reset(reset), .dcm_locked(dcm_locked), .run_sw(run_sw),
    .step_btn(step_btn), .gwe(gwe), .proc_rst(proc_rst), .phase(phase), .state(state));
  reset_gwe_seq #(.DIV(2), .HOLD(1)) dut_b (.clk_16MHz(clk), .reset(reset_b), .dcm_locked(1'b1),
    .run_sw(1'b1), .step_btn(1'b0), .gwe(gwe_b), .proc_rst(proc_rst_b), .phase(phase_b), .state(state_b));
  task automatic count_a(input int cyc, output int n, output int off);
    n = 0;
    off = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (gwe) begin
        n++;
        if (phase != 0) off++;
      end
    end
  endtask
  task automatic hold_a(output int n, output int gap_bad, output bit to);
    int last = -1;
    n = 0;
    gap_bad = 0;
    to = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!proc_rst) begin
        to = 1'b0;
        break;
      end
      if (gwe) begin
        if (last >= 0 && c - last != 8) gap_bad++;
        last = c;
        n++;
      end
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    tests++; if (phase !== 3'd0) begin fails++; $display("FAIL reset_phase got %0d want 0", phase); end
    tests++; if (gwe !== 1'b0) begin fails++; $display("FAIL reset_gwe got %b want 0", gwe); end
    tests++; if (proc_rst !== 1'b1) begin fails++; $display("FAIL reset_proc_rst got %b want 1", proc_rst); end
  endtask
  task automatic test_hold_run;
    int n, gap, off, e;
    bit to;
    exp_q.push_back(16);
    exp_q.push_back(5);
    reset = 1'b0;
    hold_a(n, gap, to);
    e = exp_q.pop_front();
    tests++; if (to || n !== e) begin fails++; $display("FAIL hold_pulses got %0d want %0d (timeout %b)", n, e, to); end
    tests++; if (gap !== 0) begin fails++; $display("FAIL hold_gap got %0d bad gaps want 0", gap); end
    count_a(40, n, off);
    e = exp_q.pop_front();
    tests++; if (n !== e) begin fails++; $display("FAIL run_pulses got %0d want %0d", n, e); end
    tests++; if (off !== 0) begin fails++; $display("FAIL run_phase got %0d off-phase want 0", off); end
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL run_state got %0d want 2", state); end
  endtask
  task automatic test_step;
    int n = 0, off = 0, k, o, e;
    run_sw = 1'b0;
    repeat (24) @(negedge clk);
    tests++; if (state !== 2'd3) begin fails++; $display("FAIL step_state got %0d want 3", state); end
    exp_q.push_back(3);
    repeat (3) begin
      step_btn = 1'b1;
      count_a(4, k, o);
      n += k; off += o;
      step_btn = 1'b0;
      count_a(16, k, o);
      n += k; off += o;
    end
    count_a(10, k, o);
    n += k; off += o;
    e = exp_q.pop_front();
    tests++; if (n !== e) begin fails++; $display("FAIL step_pulses got %0d want %0d", n, e); end
    tests++; if (off !== 0) begin fails++; $display("FAIL step_phase got %0d off-phase want 0", off); end
  endtask
  task automatic test_double_step;
    int n, off, e;
    bit found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      found = phase == 3'd1;
    end
    tests++; if (!found) begin fails++; $display("FAIL double_align got no phase 1 want phase 1"); end
    exp_q.push_back(1);
    step_btn = 1'b1;
    @(negedge clk);
    step_btn = 1'b0;
    repeat (2) @(negedge clk);
    step_btn = 1'b1;
    @(negedge clk);
    step_btn = 1'b0;
    count_a(24, n, off);
    e = exp_q.pop_front();
    tests++; if (n !== e) begin fails++; $display("FAIL double_step got %0d pulses want %0d", n, e); end
  endtask
  task automatic test_lock_loss;
    int n, gap, e;
    bit to, hit = 1'b0;
    run_sw = 1'b1;
    repeat (24) @(negedge clk);
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL relock_pre_state got %0d want 2", state); end
    dcm_locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (state == 2'd0 && proc_rst) hit = 1'b1;
    end
    tests++; if (!hit) begin fails++; $display("FAIL lock_loss got state %0d proc_rst %b want 0/1", state, proc_rst); end
    repeat (10) @(negedge clk);
    exp_q.push_back(16);
    dcm_locked = 1'b1;
    hold_a(n, gap, to);
    e = exp_q.pop_front();
    tests++; if (to || n !== e) begin fails++; $display("FAIL relock_hold got %0d want %0d (timeout %b)", n, e, to); end
    tests++; if (gap !== 0) begin fails++; $display("FAIL relock_gap got %0d bad gaps want 0", gap); end
  endtask
  task automatic test_reset_mid_hold;
    int n = 0, gap, off, e;
    bit to;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 300 && n < 10; i++) begin
      @(negedge clk);
      if (gwe && proc_rst) n++;
    end
    tests++; if (dut.hold_cnt !== 4'd5) begin fails++; $display("FAIL mid_hold_cnt got %0d want 5", dut.hold_cnt); end
    #2 reset = 1'b1;
    #1;
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL mid_reset_state got %0d want 0", state); end
    tests++; if (phase !== 3'd0) begin fails++; $display("FAIL mid_reset_phase got %0d want 0", phase); end
    tests++; if (gwe !== 1'b0) begin fails++; $display("FAIL mid_reset_gwe got %b want 0", gwe); end
    tests++; if (proc_rst !== 1'b1) begin fails++; $display("FAIL mid_reset_proc_rst got %b want 1", proc_rst); end
    count_a(20, n, off);
    tests++; if (n !== 0) begin fails++; $display("FAIL gwe_in_reset got %0d want 0", n); end
    exp_q.push_back(16);
    reset = 1'b0;
    hold_a(n, gap, to);
    e = exp_q.pop_front();
    tests++; if (to || n !== e) begin fails++; $display("FAIL rehold_pulses got %0d want %0d (timeout %b)", n, e, to); end
    tests++; if (gap !== 0) begin fails++; $display("FAIL rehold_gap got %0d bad gaps want 0", gap); end
  endtask
  task automatic test_div2;
    int n = 0, off = 0, e;
    bit to = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(10);
    reset_b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!proc_rst_b) begin
        to = 1'b0;
        break;
      end
      if (gwe_b) n++;
    end
    e = exp_q.pop_front();
    tests++; if (to || n !== e) begin fails++; $display("FAIL div2_hold got %0d want %0d (timeout %b)", n, e, to); end
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (gwe_b) begin
        n++;
        if (phase_b != 1'b0) off++;
      end
    end
    e = exp_q.pop_front();
    tests++; if (n !== e) begin fails++; $display("FAIL div2_run got %0d want %0d", n, e); end
    tests++; if (off !== 0) begin fails++; $display("FAIL div2_phase got %0d off-phase want 0", off); end
  endtask
  initial begin
    test_reset;
    test_hold_run;
    test_step;
    test_double_step;
    test_lock_loss;
    test_reset_mid_hold;
    test_div2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
